// File: rtl/gf233_mult_arbiter_pkg.sv
// Shared constants for the GF(2^233) multiplier arbiter: field size, default latency, id sizing.
package gf233_mult_arbiter_pkg;

  localparam int M          = 233;
  localparam int LAT_DEF    = 3;
  localparam int N_REQ_MAX  = 8;

  // x^233 + x^74 + 1, bit 233 included
  localparam logic [M:0] FIELD_POLY = (234'd1 << 233) | (234'd1 << 74) | 234'd1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf233_mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: operand requests in, tagged products out.
interface gf233_mult_arbiter_if
  import gf233_mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*M-1:0] req_a;
  logic [N_REQ*M-1:0] req_b;
  logic [N_REQ-1:0]   rsp_valid;
  logic [M-1:0]       rsp_c;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_c
  );

endinterface

// File: rtl/gf233_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
module rr_arbiter
  import gf233_mult_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           found
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/gf233_mult_arbiter.sv
// Shares one pipelined GF(2^233) multiplier among N_REQ requesters; tags route each product
// back to its issuer LAT+1 cycles after acceptance.
module gf233_mult_arbiter
  import gf233_mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  gf233_mult_arbiter_if.slave   bus,
  output logic [M-1:0]          mult_a,
  output logic [M-1:0]          mult_b,
  input  logic [M-1:0]          mult_c,
  output logic                  busy
);

  localparam int IDW = id_w(N_REQ);

  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          gnt_idx;
  logic [N_REQ-1:0]        gnt;
  logic                    accept;
  logic [LAT:0]            tag_vld;
  logic [LAT:0][IDW-1:0]   tag_id;
  logic [N_REQ-1:0]        rsp_vld;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (accept)
  );

  assign bus.req_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Issue stage: operands of the granted requester are registered toward the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (accept) begin
      mult_a <= bus.req_a[int'(gnt_idx)*M +: M];
      mult_b <= bus.req_b[int'(gnt_idx)*M +: M];
    end
  end

  // Tag pipe: tag_vld[LAT] lines up with the cycle mult_c carries this issue's product
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-1:0], accept};
      tag_id  <= {tag_id[LAT-1:0], gnt_idx};
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (tag_vld[LAT]) rsp_vld[tag_id[LAT]] = 1'b1;
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_c     = mult_c;
  assign busy          = (|bus.req_valid) | (|tag_vld);

endmodule
